// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Loads a byte-stream program image into the instruction memory.
//             Stream format: 2-byte little-endian word count N, followed by
//             N little-endian 32-bit instructions. The core is held in reset
//             until the image has been written completely.
//  Options  : IMEM_LOADER_CHECKSUM_EN - expect one trailing byte equal to the
//             XOR of all payload bytes; a mismatch aborts into ERR.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
   parameter int INSTR_MEM_SIZE_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  byte_data,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        core_hold
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM   = 3'd4,
`endif
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   // Capacity kept at 32 bits so the N*4 compare never truncates.
   localparam logic [31:0] c_MEM_BYTES = 32'(INSTR_MEM_SIZE_BYTES);

   // State entered after the final payload word has been accepted.
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t c_FINISH = S_CSUM;
`else
   localparam state_t c_FINISH = S_DONE;
`endif

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_len;
   logic [15:0] r_word_idx;
   logic [1:0]  r_byte_idx;
   logic [23:0] r_word;
   logic        r_wr_en;
   logic [31:0] r_wr_addr;
   logic [31:0] r_wr_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  r_csum;
`endif

   logic        w_fire;
   logic        w_start_ok;
   logic [15:0] w_len_full;
   logic        w_oversize;
   logic        w_last_word;

   assign w_fire      = byte_valid && byte_ready;
   assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
   // Word count as it becomes complete while the LEN_HI byte is on the bus.
   assign w_len_full  = {byte_data, r_len[7:0]};
   assign w_oversize  = {14'd0, w_len_full, 2'b00} > c_MEM_BYTES;
   // 17-bit compare so that N==0 can never look like a wrapped last index.
   assign w_last_word = ({1'b0, r_word_idx} + 17'd1) == {1'b0, r_len};

   assign wr_en   = r_wr_en;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and status outputs derived from the current state
   always_comb begin
      w_state_next = r_state;
      byte_ready   = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      error        = 1'b0;
      core_hold    = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid) w_state_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid) begin
               if (w_oversize)              w_state_next = S_ERR;
               else if (w_len_full == 16'd0) w_state_next = c_FINISH;
               else                          w_state_next = S_DATA;
            end
         end
         S_DATA: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid && (r_byte_idx == 2'd3) && w_last_word) w_state_next = c_FINISH;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid) w_state_next = (byte_data == r_csum) ? S_DONE : S_ERR;
         end
`endif
         S_DONE: begin
            done      = 1'b1;
            core_hold = 1'b0;
            if (start) w_state_next = S_LEN_LO;
         end
         S_ERR: begin
            error = 1'b1;
            if (start) w_state_next = S_LEN_LO;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Header capture, word assembly and the registered memory write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len      <= 16'd0;
         r_word_idx <= 16'd0;
         r_byte_idx <= 2'd0;
         r_word     <= 24'd0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= 32'd0;
         r_wr_data  <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum     <= 8'd0;
`endif
      end else begin
         r_wr_en <= 1'b0;
         if (w_start_ok) begin
            r_len      <= 16'd0;
            r_word_idx <= 16'd0;
            r_byte_idx <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
         end else if (w_fire) begin
            case (r_state)
               S_LEN_LO: r_len[7:0]  <= byte_data;
               S_LEN_HI: r_len[15:8] <= byte_data;
               S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum <= r_csum ^ byte_data;
`endif
                  r_byte_idx <= r_byte_idx + 2'd1;
                  case (r_byte_idx)
                     2'd0: r_word[7:0]   <= byte_data;
                     2'd1: r_word[15:8]  <= byte_data;
                     2'd2: r_word[23:16] <= byte_data;
                     default: begin
                        r_wr_en    <= 1'b1;
                        r_wr_addr  <= {14'd0, r_word_idx, 2'b00};
                        r_wr_data  <= {byte_data, r_word};
                        r_word_idx <= r_word_idx + 16'd1;
                     end
                  endcase
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader. A queue of expected writes
//             is built from each image and checked on every write strobe;
//             directed vectors pin literal addresses, data and status.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   localparam int MEM = 1024;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        error;
   logic        core_hold;

   imem_loader #(.INSTR_MEM_SIZE_BYTES(MEM)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .core_hold  (core_hold)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      bit          last;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] img [0:255];
   logic [31:0] log_addr [0:1023];
   logic [31:0] log_data [0:1023];
   int          log_cnt = 0;
   int          total = 0;
   int          bad = 0;
   logic        noise_start = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   // XOR of all payload bytes of the first n image words
   function automatic logic [7:0] model_xor(input int n);
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < n; i++)
         for (int k = 0; k < 4; k++) x ^= img[i][8*k +: 8];
      return x;
   endfunction

   // Every write strobe is matched against the model's expected write queue
   always @(negedge clk) begin
      wr_t e;
      if (rst_n && wr_en) begin
         log_addr[log_cnt] = wr_addr;
         log_data[log_cnt] = wr_data;
         log_cnt++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr=%h data=%h want no write", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
            if (e.last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk("last_write_busy", {31'd0, busy}, 32'd1);
               chk("last_write_done", {31'd0, done}, 32'd0);
`else
               chk("last_write_done", {31'd0, done}, 32'd1);
               chk("last_write_core_hold", {31'd0, core_hold}, 32'd0);
`endif
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      byte_data  = b;
      byte_valid = 1'b1;
      start      = noise_start;
      while (!byte_ready && n < 40) begin
         tick();
         n++;
      end
      if (n == 40) chk("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
      tick();
      byte_valid = 1'b0;
      start      = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
      chk({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
      chk({tag, "_wr_addr"},    wr_addr,             32'd0);
      chk({tag, "_wr_data"},    wr_data,             32'd0);
      chk({tag, "_busy"},       {31'd0, busy},       32'd0);
      chk({tag, "_done"},       {31'd0, done},       32'd0);
      chk({tag, "_error"},      {31'd0, error},      32'd0);
      chk({tag, "_core_hold"},  {31'd0, core_hold},  32'd1);
   endtask

   // Full session: header, payload, optional checksum byte, final status
   task automatic load(input int n, input int gap, input logic [7:0] csum);
      logic [15:0] nn;
      bit          ok_size;
      bit          ok;
      nn      = 16'(n);
      ok_size = (n * 4 <= MEM);
      ok      = ok_size;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (ok_size) ok = (csum == model_xor(n));
`endif
      pulse_start();
      chk("ready_after_start", {31'd0, byte_ready}, 32'd1);
      chk("busy_after_start",  {31'd0, busy},       32'd1);
      chk("hold_after_start",  {31'd0, core_hold},  32'd1);
      chk("done_after_start",  {31'd0, done},       32'd0);
      if (ok_size)
         for (int i = 0; i < n; i++) exp_q.push_back('{32'(i * 4), img[i], (i == n - 1)});
      send_byte(nn[7:0], gap);
      send_byte(nn[15:8], gap);
      if (ok_size) begin
         for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) send_byte(img[i][8*k +: 8], gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
         send_byte(csum, gap);
`endif
      end
      repeat (3) tick();
      chk("end_done",       {31'd0, done},        {31'd0, ok});
      chk("end_error",      {31'd0, error},       {31'd0, !ok});
      chk("end_core_hold",  {31'd0, core_hold},   {31'd0, !ok});
      chk("end_busy",       {31'd0, busy},        32'd0);
      chk("end_byte_ready", {31'd0, byte_ready},  32'd0);
      chk("end_pending",    32'(exp_q.size()),    32'd0);
      exp_q.delete();
   endtask

   task automatic set_two_words();
      img[0] = 32'h00A00513;
      img[1] = 32'h00B00593;
   endtask

   initial begin
      int l0;
      rst_n      = 1'b0;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) tick();
      chk_reset_vals("in_reset");
      rst_n = 1'b1;
      repeat (2) tick();
      chk_reset_vals("after_reset");

      // Two-word load, continuous stream
      set_two_words();
      l0 = log_cnt;
      load(2, 0, model_xor(2));
      chk("t1_count", 32'(log_cnt - l0), 32'd2);
      chk("t1_addr0", log_addr[l0],     32'h0);
      chk("t1_data0", log_data[l0],     32'h00A00513);
      chk("t1_addr1", log_addr[l0 + 1], 32'h4);
      chk("t1_data1", log_data[l0 + 1], 32'h00B00593);

      // Backpressure: 3 idle cycles between bytes
      l0 = log_cnt;
      load(2, 3, model_xor(2));
      chk("t2_count", 32'(log_cnt - l0), 32'd2);
      chk("t2_data1", log_data[l0 + 1], 32'h00B00593);

      // start asserted throughout a session must be ignored
      noise_start = 1'b1;
      l0 = log_cnt;
      load(2, 1, model_xor(2));
      noise_start = 1'b0;
      chk("t3_count", 32'(log_cnt - l0), 32'd2);

      // Empty image
      l0 = log_cnt;
      load(0, 0, 8'h00);
      chk("t4_count", 32'(log_cnt - l0), 32'd0);
      chk("t4_done",  {31'd0, done}, 32'd1);

      // Oversize image N=0x0101 (1028 bytes)
      l0 = log_cnt;
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      chk("t5_error",      {31'd0, error},      32'd1);
      chk("t5_byte_ready", {31'd0, byte_ready}, 32'd0);
      chk("t5_core_hold",  {31'd0, core_hold},  32'd1);
      chk("t5_busy",       {31'd0, busy},       32'd0);
      repeat (5) tick();
      chk("t5_count", 32'(log_cnt - l0), 32'd0);
      img[0] = 32'h12345678;
      load(1, 0, model_xor(1));
      chk("t5_recover_done", {31'd0, done}, 32'd1);

      // Boundary: N=256 fills the memory exactly
      for (int i = 0; i < 256; i++) img[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3};
      l0 = log_cnt;
      load(256, 0, model_xor(256));
      chk("t6_count",     32'(log_cnt - l0), 32'd256);
      chk("t6_last_addr", log_addr[l0 + 255], 32'h3FC);
      chk("t6_last_data", log_data[l0 + 255], 32'hFF00A5C3);

      // Reset after 6 payload bytes: only word 0 may ever be written
      set_two_words();
      l0 = log_cnt;
      pulse_start();
      exp_q.push_back('{32'h0, img[0], 1'b0});
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 0);
      send_byte(img[1][7:0], 0);
      send_byte(img[1][15:8], 0);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("mid_reset");
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("t7_count", 32'(log_cnt - l0), 32'd1);
      chk("t7_addr0", log_addr[l0], 32'h0);
      chk("t7_data0", log_data[l0], 32'h00A00513);
      chk_reset_vals("post_reset");
      exp_q.delete();

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum good (B6) and bad (B7)
      img[0] = 32'h00A00513;
      load(1, 0, 8'hB6);
      chk("t8_good_done", {31'd0, done}, 32'd1);
      l0 = log_cnt;
      load(1, 0, 8'hB7);
      chk("t8_bad_error", {31'd0, error}, 32'd1);
      chk("t8_bad_write", log_data[l0], 32'h00A00513);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the run always terminates
   initial begin
      #2000000;
      $display("FAIL global_timeout: got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Program loader that writes a byte-stream image into the instruction memory before the core runs. It consumes a valid/ready byte stream carrying a 2-byte little-endian word count followed by that many 32-bit instructions. It assembles the instruction bytes little-endian, drives the instruction memory write port one word per write, and holds the core in reset until the image is fully loaded.

## Interface
- INSTR_MEM_SIZE_BYTES, 1024, size of the target instruction memory in bytes (multiple of 4); bounds the accepted word count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load session; honoured only in IDLE, DONE or ERR.
- byte_data  in  8  stream byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  loader accepts a byte; a transfer occurs on byte_valid && byte_ready.
- wr_en  out  1  one-cycle instruction memory write strobe.
- wr_addr  out  32  byte address of the write, word aligned.
- wr_data  out  32  instruction word to write.
- busy  out  1  session in progress.
- done  out  1  image loaded successfully; held until next start.
- error  out  1  session aborted; held until next start.
- core_hold  out  1  keeps the core in reset; high from reset until done.

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM (macro only), DONE, ERR.
- IDLE/DONE/ERR + start → LEN_LO. Entering LEN_LO clears done, error and the word/byte counters, and sets core_hold=1 and busy=1.
- LEN_LO: accepted byte → N[7:0]; goes to LEN_HI. LEN_HI: accepted byte → N[15:8]; then:
  - N*4 > INSTR_MEM_SIZE_BYTES → ERR (the compare is done at ≥18 bits, with no truncation).
  - N==0 → DONE (or CSUM with the macro).
  - Otherwise → DATA.
- DATA: byte k (0..3) of the current word goes into lane [8k+7:8k]. When byte 3 is accepted, the word is written to wr_addr = word_idx*4 and word_idx increments. After word N-1 the FSM goes to DONE (or CSUM).
- byte_ready=1 only in LEN_LO, LEN_HI, DATA and CSUM. It is 0 in IDLE, DONE and ERR.
- start is ignored while busy.
- DONE: done=1, core_hold=0, busy=0.
- ERR: error=1, core_hold=1, busy=0, no further writes.
- Reset mid-session: all state is discarded and the FSM returns to IDLE. Any partially assembled word is never written.

## Timing
- Reset values:
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - busy=0, done=0, error=0, core_hold=1.
  - FSM in IDLE.
- start sampled at cycle T → byte_ready=1 at T+1.
- Write latency:
  - wr_en, wr_addr and wr_data are registered.
  - They are valid for exactly one cycle, the cycle after byte 3 of a word is accepted.
  - wr_addr and wr_data hold their values afterwards; wr_en returns to 0.
- Throughput: one byte per cycle. Back-to-back words give one wr_en every 4 cycles. byte_valid gaps stall the FSM with no loss of state.
- Final word without the macro: done rises in the same cycle as the final wr_en, and core_hold falls in that cycle.
- ERR from an oversize N: error rises the cycle after the LEN_HI byte is accepted.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last data word, the FSM enters CSUM and accepts one byte.
  - That byte is compared with the XOR of all payload bytes. Header bytes are excluded. The XOR of zero payload bytes is 0x00.
  - Match → DONE. Mismatch → ERR.
  - Either result is flagged the cycle after the checksum byte is accepted. The final wr_en occurs in the first CSUM cycle.
  - All writes already performed remain in memory.
- IMEM_LOADER_CHECKSUM_EN not defined: there is no CSUM state and no trailing byte. The FSM goes directly to DONE as described under Timing.

## Test plan
- Two-word load, macro off: start, then stream 02 00 13 05 A0 00 93 05 B0 00 with byte_valid held high.
  - Writes: wr_en at addr 0x0 with data 0x00A00513, then at addr 0x4 with data 0x00B00593.
  - done=1 and core_hold=0 in the cycle of the second write.
- Backpressure: same image with byte_valid deasserted for 3 cycles between every byte → identical writes and values; no extra or lost wr_en.
- Empty image: stream 00 00 → no wr_en, done=1, error=0. With the macro, also send 00 and expect done=1.
- Oversize image, INSTR_MEM_SIZE_BYTES=1024, N=0x0101 → error=1, byte_ready=0, no wr_en, core_hold=1. A following start and a valid image then yields done=1.
- Reset mid-load: assert rst_n=0 after 6 payload bytes. Expect every output at its reset value, and no write to addr 0x4.
- Checksum, macro on: image 01 00 13 05 A0 00 with trailing byte B6 → done=1. With trailing byte B7 → error=1, although the write of 0x00A00513 at addr 0x0 still occurred.
